// File: rtl/sdram_auto_refresh.sv
// Auto-refresh sequencer for a 16-bit SDR SDRAM: periodic request, then PRECHARGE-ALL + AUTO REFRESH.
// Define SDRAM_AR_DOUBLE_EN to issue two AUTO REFRESH commands per request instead of one.
module sdram_auto_refresh #(
    parameter int AR_PERIOD   = 750,
    parameter int TRP_CYCLES  = 2,
    parameter int TRFC_CYCLES = 7
) (
    input  logic        ar_clk,
    input  logic        ar_rst,
    input  logic        init_end,
    input  logic        ar_en,
    output logic [3:0]  ar_cmd,
    output logic [1:0]  ar_bank,
    output logic [12:0] ar_addr,
    output logic        ar_req,
    output logic        ar_end
);
    localparam int TIMER_W  = (AR_PERIOD > 1) ? $clog2(AR_PERIOD) : 1;
    localparam int WAIT_MAX = (TRP_CYCLES > TRFC_CYCLES) ? TRP_CYCLES : TRFC_CYCLES;
    localparam int WAIT_W   = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(AR_PERIOD - 1);
    localparam logic [WAIT_W-1:0]  TRP_LAST   = WAIT_W'(TRP_CYCLES - 1);
    localparam logic [WAIT_W-1:0]  TRFC_LAST  = WAIT_W'(TRFC_CYCLES - 1);

`ifdef SDRAM_AR_DOUBLE_EN
    localparam logic [1:0] REF_TOTAL = 2'd2;
`else
    localparam logic [1:0] REF_TOTAL = 2'd1;
`endif

    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b000,
        ST_PRE  = 3'b001,
        ST_TRP  = 3'b011,
        ST_AR   = 3'b010,
        ST_TRFC = 3'b110,
        ST_END  = 3'b111
    } state_e;

    state_e              state_q, state_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic                req_q, req_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [1:0]          ref_q, ref_d;
    logic                timerWrap;

    assign ar_bank = 2'b11;
    assign ar_addr = 13'h1FFF;
    assign ar_req  = req_q;

    assign timerWrap = init_end && (timer_q == TIMER_LAST);

    // A wrap always wins over a grant so a request arriving mid-sequence is not lost.
    always_comb begin
        timer_d = timer_q;
        req_d   = req_q;
        if (!init_end || timerWrap) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + 1'b1;
        end
        if (timerWrap) begin
            req_d = 1'b1;
        end else if (ar_en) begin
            req_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        ref_d   = ref_q;
        ar_cmd  = CMD_NOP;
        ar_end  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                ref_d = '0;
                if (ar_en) state_d = ST_PRE;
            end
            ST_PRE: begin
                ar_cmd  = CMD_PRE;
                state_d = ST_TRP;
            end
            ST_TRP: begin
                if (wait_q == TRP_LAST) state_d = ST_AR;
                else                    wait_d  = wait_q + 1'b1;
            end
            ST_AR: begin
                ar_cmd  = CMD_REF;
                ref_d   = ref_q + 1'b1;
                state_d = ST_TRFC;
            end
            ST_TRFC: begin
                if (wait_q == TRFC_LAST) state_d = (ref_q < REF_TOTAL) ? ST_AR : ST_END;
                else                     wait_d  = wait_q + 1'b1;
            end
            ST_END: begin
                ar_end  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // The wait counter is shared by TRP and TRFC, so every transition restarts it.
        if (state_d != state_q) wait_d = '0;
    end

    always_ff @(posedge ar_clk) begin
        if (ar_rst) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            req_q   <= 1'b0;
            wait_q  <= '0;
            ref_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            req_q   <= req_d;
            wait_q  <= wait_d;
            ref_q   <= ref_d;
        end
    end

endmodule

// File: tb/tb_sdram_auto_refresh.sv
// Self-checking bench for sdram_auto_refresh: a command-queue reference model checked every cycle,
// plus targeted cadence, steady-state, and mid-sequence reset checks.
module tb_sdram_auto_refresh;
    localparam int AR_PERIOD   = 750;
    localparam int TRP_CYCLES  = 2;
    localparam int TRFC_CYCLES = 7;
`ifdef SDRAM_AR_DOUBLE_EN
    localparam int N_REF = 2;
`else
    localparam int N_REF = 1;
`endif
    localparam int SEQ_LEN   = 2 + TRP_CYCLES + N_REF * (1 + TRFC_CYCLES);
    localparam int RST_IDX   = SEQ_LEN - 4;
    localparam int END_TOKEN = 16;

    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;

    logic        ar_clk = 1'b0;
    logic        ar_rst;
    logic        init_end;
    logic        ar_en;
    logic [3:0]  ar_cmd;
    logic [1:0]  ar_bank;
    logic [12:0] ar_addr;
    logic        ar_req;
    logic        ar_end;

    sdram_auto_refresh #(
        .AR_PERIOD  (AR_PERIOD),
        .TRP_CYCLES (TRP_CYCLES),
        .TRFC_CYCLES(TRFC_CYCLES)
    ) dut (
        .ar_clk  (ar_clk),
        .ar_rst  (ar_rst),
        .init_end(init_end),
        .ar_en   (ar_en),
        .ar_cmd  (ar_cmd),
        .ar_bank (ar_bank),
        .ar_addr (ar_addr),
        .ar_req  (ar_req),
        .ar_end  (ar_end)
    );

    always #5 ar_clk = ~ar_clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: expected command stream as a queue, request as a flag set on period boundaries.
    int   seqQ[$];
    logic modelReq   = 1'b0;
    int   initEdges  = 0;
    int   grantCount = 0;

    int   cycle         = 0;
    logic prevReq       = 1'b0;
    int   lastRiseCycle = 0;
    int   lastRefCycle  = -1;
    int   preCount      = 0;
    bit   checkSpacing  = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s at cycle %0d: observed %0h, expected %0h", tag, cycle, observed, expected);
        end
    endtask

    task automatic modelEdge();
        bit wrap;
        wrap = 1'b0;
        if (ar_rst) begin
            seqQ.delete();
            modelReq  = 1'b0;
            initEdges = 0;
        end else begin
            if (init_end) begin
                initEdges++;
                wrap = (initEdges % AR_PERIOD) == 0;
            end else begin
                initEdges = 0;
            end
            if (wrap)       modelReq = 1'b1;
            else if (ar_en) modelReq = 1'b0;
            if (seqQ.size() == 0) begin
                if (ar_en) begin
                    grantCount++;
                    seqQ.push_back(int'(CMD_PRE));
                    for (int i = 0; i < TRP_CYCLES; i++) seqQ.push_back(int'(CMD_NOP));
                    for (int r = 0; r < N_REF; r++) begin
                        seqQ.push_back(int'(CMD_REF));
                        for (int i = 0; i < TRFC_CYCLES; i++) seqQ.push_back(int'(CMD_NOP));
                    end
                    seqQ.push_back(END_TOKEN);
                end
            end else begin
                void'(seqQ.pop_front());
            end
        end
    endtask

    function automatic logic [3:0] expCmd();
        if (seqQ.size() == 0 || seqQ[0] == END_TOKEN) return CMD_NOP;
        return 4'(seqQ[0]);
    endfunction

    function automatic logic expEnd();
        return (seqQ.size() != 0) && (seqQ[0] == END_TOKEN);
    endfunction

    task automatic observe();
        if (ar_req === 1'b1 && prevReq !== 1'b1) lastRiseCycle = cycle;
        prevReq = ar_req;
        if (ar_cmd === CMD_PRE) begin
            preCount++;
            if (lastRefCycle >= 0) checkOutput("refToPreGap", 32'((cycle - lastRefCycle) > TRFC_CYCLES), 1);
            if (checkSpacing) checkOutput("reqToPre", cycle - lastRiseCycle, 2);
        end
        if (ar_cmd === CMD_REF) lastRefCycle = cycle;
    endtask

    task automatic applyStimulus(input logic rst, input logic init, input logic en);
        ar_rst   = rst;
        init_end = init;
        ar_en    = en;
        @(posedge ar_clk);
        modelEdge();
        #1;
        cycle++;
        checkOutput("cmd",  ar_cmd,  expCmd());
        checkOutput("req",  ar_req,  modelReq);
        checkOutput("end",  ar_end,  expEnd());
        checkOutput("bank", ar_bank, 2'b11);
        checkOutput("addr", ar_addr, 13'h1FFF);
        observe();
    endtask

    // Arbiter: grants a pending request after a delay, holds the grant until ar_end, optionally glitches.
    task automatic runArbiter(input int cycles, input int minDelay, input int maxDelay, input bit chaos);
        logic en;
        int   delay;
        int   initLowLeft;
        logic enDrive;
        en          = 1'b0;
        delay       = $urandom_range(maxDelay, minDelay);
        initLowLeft = 0;
        for (int i = 0; i < cycles; i++) begin
            if (!en && ar_req === 1'b1) begin
                if (delay == 0) en = 1'b1;
                else            delay--;
            end
            enDrive = en;
            if (chaos && en && $urandom_range(7, 0) == 0) enDrive = 1'b0;
            if (chaos && initLowLeft == 0 && $urandom_range(1499, 0) == 0) initLowLeft = $urandom_range(20, 1);
            applyStimulus(1'b0, initLowLeft == 0, enDrive);
            if (initLowLeft > 0) initLowLeft--;
            if (ar_end === 1'b1) begin
                en    = 1'b0;
                delay = $urandom_range(maxDelay, minDelay);
            end
        end
    endtask

    initial begin
        int  initStart;
        int  firstRise;
        int  preBase;
        int  t;
        bit  seen;

        repeat (10)   applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (2000) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("idlePreCount", preCount, 0);

        $display("[TB] request cadence");
        initStart = cycle;
        firstRise = -1;
        for (int i = 0; i < 2 * AR_PERIOD + 100; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            if (firstRise < 0 && ar_req === 1'b1) firstRise = cycle - initStart;
        end
        checkOutput("firstReqDelay", firstRise, AR_PERIOD);

        $display("[TB] steady state over 10 periods");
        applyStimulus(1'b1, 1'b1, 1'b0);
        preBase      = preCount;
        checkSpacing = 1'b1;
        runArbiter(10 * AR_PERIOD + SEQ_LEN + 5, 1, 1, 1'b0);
        checkSpacing = 1'b0;
        checkOutput("steadySeqCount", preCount - preBase, 10);

        $display("[TB] reset inside the last TRFC window");
        seen = 1'b0;
        t    = 0;
        while (!seen && t < 2 * AR_PERIOD) begin
            applyStimulus(1'b0, 1'b1, ar_req === 1'b1);
            if (ar_cmd === CMD_PRE) seen = 1'b1;
            t++;
        end
        checkOutput("rstTestGrant", 32'(seen), 1);
        repeat (RST_IDX) applyStimulus(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("rstCmd", ar_cmd, CMD_NOP);
        checkOutput("rstReq", ar_req, 0);
        checkOutput("rstEnd", ar_end, 0);
        initStart = cycle;
        firstRise = -1;
        for (int i = 0; i < AR_PERIOD + 10; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            if (firstRise < 0 && ar_req === 1'b1) firstRise = cycle - initStart;
        end
        checkOutput("reqAfterReset", firstRise, AR_PERIOD);

        $display("[TB] randomized arbiter");
        runArbiter(4000, 0, 3, 1'b1);
        checkOutput("grantCount", preCount, grantCount);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sdram_auto_refresh.md
# sdram_auto_refresh

Auto-refresh controller for a 16-bit SDR SDRAM (W989DxDB class) running at 100 MHz. It sits beside the power-up initializer and behind the command arbiter. Once initialization completes, it periodically raises a refresh request. When the arbiter grants the request, it issues PRECHARGE-ALL followed by one or two AUTO REFRESH commands, honouring tRP and tRFC, and then pulses a done flag.

## Interface
Parameters:
- AR_PERIOD, 750 — cycles between refresh requests (7.5 µs at 100 MHz, under the 7.8 µs row budget).
- TRP_CYCLES, 2 — NOP cycles after PRECHARGE.
- TRFC_CYCLES, 7 — NOP cycles after each AUTO REFRESH.

Ports:
- ar_clk  in  1 — clock; the only clock. All logic is on the rising edge.
- ar_rst  in  1 — reset, synchronous, active-high.
- init_end  in  1 — high once SDRAM initialization is complete. It gates the interval timer.
- ar_en  in  1 — grant from the arbiter. Held high until ar_end.
- ar_cmd  out  4 — {cs_n, ras_n, cas_n, we_n}.
- ar_bank  out  2 — bank address.
- ar_addr  out  13 — address bus.
- ar_req  out  1 — refresh request, registered.
- ar_end  out  1 — one-cycle completion pulse.

## Operation
- Command encodings:
  - NOP = 4'b0111
  - PRECHARGE = 4'b0010
  - AUTO REFRESH = 4'b0001
- ar_bank is constant 2'b11. ar_addr is constant 13'h1FFF, so A10=1 and PRECHARGE always means precharge-all.
- Interval timer:
  - Counts 0..AR_PERIOD-1 and wraps while init_end=1.
  - Held at 0 while init_end=0.
  - On the cycle the count equals AR_PERIOD-1, ar_req is set at the next edge.
- ar_req clears at the edge where ar_en=1. A wrap while ar_req is already high has no additional effect; requests are not queued.
- FSM states use 3-bit Gray encoding:
  - IDLE=000: cmd NOP. Goes to PRE when ar_en=1.
  - PRE=001: cmd PRECHARGE for 1 cycle. Goes to TRP.
  - TRP=011: cmd NOP for TRP_CYCLES cycles. Goes to AR.
  - AR=010: cmd AUTO REFRESH for 1 cycle. Goes to TRFC.
  - TRFC=110: cmd NOP for TRFC_CYCLES cycles. Goes to AR again if refreshes remain, otherwise to END.
  - END=111: cmd NOP and ar_end=1 for 1 cycle. Goes to IDLE.
- A shared wait counter times TRP and TRFC. It is cleared on every state change.
- A refresh counter tracks how many AUTO REFRESH commands have been issued in the current sequence. It is cleared in IDLE.
- ar_cmd and ar_end are decoded combinationally from the registered state. ar_req is registered.
- ar_en deasserting mid-sequence is ignored; a started sequence always runs to END.
- ar_en=1 while init_end=0 is still obeyed. The arbiter is responsible for gating the grant.

## Timing
- Reset values: state IDLE, ar_cmd=NOP, ar_bank=2'b11, ar_addr=13'h1FFF, ar_req=0, ar_end=0, all counters 0.
- Reset asserted mid-sequence takes the block to IDLE at the next edge, with ar_cmd=NOP from that cycle on.
- First ar_req is AR_PERIOD cycles after init_end rises. Subsequent ones follow every AR_PERIOD cycles, independent of sequence length.
- Grant latency: ar_en sampled high at edge k puts PRECHARGE on ar_cmd in cycle k+1.
- Sequence length is 1 + TRP_CYCLES + N×(1+TRFC_CYCLES) + 1 cycles, where N is the number of refreshes:
  - N=2 with defaults: 20 cycles.
  - N=1 with defaults: 12 cycles.
- ar_end is high only in the END cycle. The arbiter drops ar_en at the following edge, while the FSM is back in IDLE.
- Simultaneous timer wrap and ar_en=1 in IDLE: ar_req is set (a new request), and the sequence starts.

## Configuration
- SDRAM_AR_DOUBLE_EN:
  - Defined: N=2. Two AUTO REFRESH commands per request, with TRFC after each.
  - Undefined: N=1. One AUTO REFRESH, then TRFC, then END.

## Test plan
- Reset and idle: ar_rst=1 for 10 cycles, then init_end=0 for 2000 cycles -> ar_req stays 0 and ar_cmd stays 4'b0111 throughout.
- Request cadence: init_end=1 with ar_en tied 0 -> ar_req rises exactly 750 cycles after init_end and stays high with no second assertion.
- Full handshake with SDRAM_AR_DOUBLE_EN defined -> in order:
  - PRECHARGE (addr 13'h1FFF, bank 2'b11), 2 NOPs
  - AUTO REFRESH, 7 NOPs
  - AUTO REFRESH, 7 NOPs
  - ar_end pulse
  - 20 cycles total; ar_req low from the grant edge.
- Without the macro -> single AUTO REFRESH, 12-cycle sequence, ar_end one cycle.
- Reset mid-TRFC: assert ar_rst during the second TRFC -> next cycle state IDLE, ar_cmd NOP, ar_req 0; interval timer restarts from 0.
- Steady state with the arbiter behaviour above over 10 periods -> exactly 10 sequences, each starting 2 cycles after ar_req rises. No PRECHARGE occurs within 7 cycles after an AUTO REFRESH.
